eu_pipe: RTL and testbench
==========================

# eu_pipe

Handshaked, registered execution unit that succeeds the combinational `eu_merge` datapath (math, gate and shift results). It sits between the decode/register-read stage and writeback. It accepts one operation per valid/ready transfer and returns a single selected result through a registered output with back-pressure. It adds a DATA_WIDTH-parametrised datapath, a legal/illegal flag, and an optional iterative multiplier.

## Interface
- DATA_WIDTH, 32: operand and result width; must be a power of two, ≥ 8.
- IMM_WIDTH, 6: immediate width; sign-extended to DATA_WIDTH.
- clk_i  input  1  clock, rising edge.
- arst_ni  input  1  reset, asynchronous, active-low.
- in_valid_i  input  1  operation request.
- in_ready_o  output  1  unit can accept; combinational from state.
- func_i  input  func_t  operation select.
- rs1_data_i  input  DATA_WIDTH  operand 1.
- rs2_data_i  input  DATA_WIDTH  operand 2.
- imm_i  input  IMM_WIDTH  immediate.
- out_valid_o  output  1  result register holds a result.
- out_ready_i  input  1  consumer accepts the result.
- result_o  output  DATA_WIDTH  result register.
- illegal_o  output  1  result is for an unsupported func_i; qualified by out_valid_o.

## Operation
- Notation: imm_ext is the sign-extended immediate. sh is the low log2(DATA_WIDTH) bits of the shift source.
- AND/OR/XOR: rs1 op rs2. NOT: ~rs1.
- ADD: rs1+rs2. ADDI: rs1+imm_ext. SUB: rs1+~rs2+1. All modulo 2^DATA_WIDTH; carry is discarded.
- SLL/SLR: rs1 <</>> sh(rs2). SLLI/SLRI: rs1 <</>> sh(imm_ext). Right shifts are logical.
- MUL (only with EU_MUL_EN): low DATA_WIDTH bits of rs1*rs2, unsigned, computed by shift-add at one bit per cycle.
- Any other func_i (including MUL without EU_MUL_EN): result 0, illegal_o=1, single-cycle path.
- FSM states:
  - IDLE → MUL when a MUL is accepted.
  - MUL → IDLE on the final iteration (counter == DATA_WIDTH-1), which also writes the output register.
- in_ready_o = (state==IDLE) && (!out_valid_o || out_ready_i).
- Accept = in_valid_i && in_ready_o. Operands are sampled only at accept.
- Output register:
  - Loads on a single-cycle accept or a MUL completion.
  - Clears out_valid_o on out_ready_i when there is no new load.
  - Holds result_o and illegal_o stable while out_valid_o && !out_ready_i.

## Timing
- Reset values: state IDLE, out_valid_o 0, result_o 0, illegal_o 0, MUL counter 0. in_ready_o reads 1.
- Single-cycle op: accept at edge N → out_valid_o high after edge N. Full throughput, one op per cycle, when out_ready_i is held high.
- MUL: accept at edge N → out_valid_o high after edge N+DATA_WIDTH-1 (DATA_WIDTH cycles). in_ready_o is 0 throughout MUL.
- Simultaneous drain and load: the old result is consumed and the new result is loaded on the same edge; out_valid_o stays 1.
- The output register is guaranteed empty during MUL, because accept required it to be empty or draining.
- Reset asserted mid-MUL or with a result pending: everything clears immediately and the partial product is discarded.
- func_i, operands and imm_i are don't-care when no accept occurs.

## Configuration
- EU_MUL_EN defined:
  - MUL decodes to the iterative multiplier and the MUL state exists.
  - Latency is DATA_WIDTH cycles.
- EU_MUL_EN undefined:
  - No multiplier logic and no MUL state; the FSM reduces to IDLE only.
  - MUL returns result 0, illegal_o=1 after one cycle.

## Structure
- simple_processor_pkg holds func_t (the existing enums plus MUL) and the DATA_WIDTH default constant.
- The imm sign-extension helper function also belongs in the package.
- One sub-module, eu_mul_iter: shift-add multiplier with start, done and counter, instantiated only under EU_MUL_EN.
- Everything else stays in eu_pipe.

## Test plan
- ADD rs1=5, rs2=7, out_ready_i=1 → result_o=12, illegal_o=0, one cycle after accept. Back-to-back ops give one result per cycle.
- ADDI rs1=10, imm=6'b111111 → 9. SUB rs1=3, rs2=5 → 0xFFFF_FFFE.
- SLRI rs1=0x8000_0000, imm=4 → 0x0800_0000. SLL rs1=1, rs2=33 → 0x2 (shift by 1).
- XOR, then out_ready_i=0 for 3 cycles → result_o stable, in_ready_o=0 for those cycles; drain on the 4th cycle, then in_ready_o=1.
- MUL 3*5 → 15 exactly 32 cycles after accept, with in_ready_o=0 throughout. MUL 0xFFFF_FFFF*2 → 0xFFFF_FFFE. Without EU_MUL_EN, MUL → result 0, illegal_o=1 after one cycle.
- arst_ni pulsed low at cycle 10 of a MUL → out_valid_o=0 and in_ready_o=1 immediately; a following ADD 1+1 → 2 with correct latency.

Source files
------------

// File: rtl/simple_processor_pkg.sv
// Shared types for the simple processor execution path: the operation encoding,
// the default datapath width and the immediate sign-extension helper.
package simple_processor_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int SEXT_MAX_WIDTH     = 64;

  typedef enum logic [3:0] {
    FUNC_AND  = 4'h0,
    FUNC_OR   = 4'h1,
    FUNC_XOR  = 4'h2,
    FUNC_NOT  = 4'h3,
    FUNC_ADD  = 4'h4,
    FUNC_ADDI = 4'h5,
    FUNC_SUB  = 4'h6,
    FUNC_SLL  = 4'h7,
    FUNC_SLR  = 4'h8,
    FUNC_SLLI = 4'h9,
    FUNC_SLRI = 4'hA,
    FUNC_MUL  = 4'hB
  } func_t;

  // Replicates bit imm_w-1 upward; callers truncate to their own width (<= 64).
  function automatic logic [SEXT_MAX_WIDTH-1:0] sext_imm(
    input logic [SEXT_MAX_WIDTH-1:0] imm,
    input int                        imm_w
  );
    logic [SEXT_MAX_WIDTH-1:0] r;
    for (int i = 0; i < SEXT_MAX_WIDTH; i++) begin
      r[i] = (i < imm_w) ? imm[i] : imm[imm_w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/eu_mul_iter.sv
// Shift-add multiplier, one multiplier bit per cycle. Bit 0 is folded into the
// start cycle so the product is ready DATA_WIDTH-1 cycles later.
module eu_mul_iter
  import simple_processor_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product
);

  localparam int              CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  logic                  busy_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [DATA_WIDTH-1:0] mcand_reg;
  logic [DATA_WIDTH-1:0] mplier_reg;
  logic [DATA_WIDTH-1:0] acc_reg;
  logic [DATA_WIDTH-1:0] acc_next;

  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign done     = busy_reg && (cnt_reg == LAST);
  assign product  = acc_next;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      busy_reg   <= 1'b0;
      cnt_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
    end else if (start) begin
      busy_reg   <= 1'b1;
      cnt_reg    <= CNT_W'(1);
      acc_reg    <= b[0] ? a : '0;
      mcand_reg  <= a << 1;
      mplier_reg <= b >> 1;
    end else if (busy_reg) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      if (done) begin
        busy_reg <= 1'b0;
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/eu_pipe.sv
// Registered, valid/ready execution unit returning one selected result per op.
// Define EU_MUL_EN to add the iterative multiplier and its MUL state.
module eu_pipe
  import simple_processor_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int IMM_WIDTH  = 6
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  func_t                 func_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic [IMM_WIDTH-1:0]  imm_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  illegal_o
);

  localparam int SH_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] imm_ext;
  logic [SH_W-1:0]       sh_rs2;
  logic [SH_W-1:0]       sh_imm;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_illegal;
  logic                  idle;
  logic                  is_mul;
  logic                  accept;
  logic                  mul_done;
  logic [DATA_WIDTH-1:0] mul_product;

  assign imm_ext = DATA_WIDTH'(sext_imm(SEXT_MAX_WIDTH'(imm_i), IMM_WIDTH));
  assign sh_rs2  = rs2_data_i[SH_W-1:0];
  assign sh_imm  = imm_ext[SH_W-1:0];

  // MUL lands in the default arm: it is illegal unless the multiplier is built.
  always_comb begin
    alu_result  = '0;
    alu_illegal = 1'b0;
    case (func_i)
      FUNC_AND:  alu_result = rs1_data_i & rs2_data_i;
      FUNC_OR:   alu_result = rs1_data_i | rs2_data_i;
      FUNC_XOR:  alu_result = rs1_data_i ^ rs2_data_i;
      FUNC_NOT:  alu_result = ~rs1_data_i;
      FUNC_ADD:  alu_result = rs1_data_i + rs2_data_i;
      FUNC_ADDI: alu_result = rs1_data_i + imm_ext;
      FUNC_SUB:  alu_result = rs1_data_i + ~rs2_data_i + DATA_WIDTH'(1);
      FUNC_SLL:  alu_result = rs1_data_i << sh_rs2;
      FUNC_SLR:  alu_result = rs1_data_i >> sh_rs2;
      FUNC_SLLI: alu_result = rs1_data_i << sh_imm;
      FUNC_SLRI: alu_result = rs1_data_i >> sh_imm;
      default:   alu_illegal = 1'b1;
    endcase
  end

  assign in_ready_o = idle && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

`ifdef EU_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t state_reg, state_next;

  assign is_mul = (func_i == FUNC_MUL);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    idle       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        idle = 1'b1;
        if (accept && is_mul) state_next = S_MUL;
      end
      S_MUL: if (mul_done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  eu_mul_iter #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .start   (accept && is_mul),
    .a       (rs1_data_i),
    .b       (rs2_data_i),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign idle        = 1'b1;
  assign is_mul      = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  // A MUL never completes while a result is pending, so the two loads are exclusive.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      out_valid_o <= 1'b0;
      result_o    <= '0;
      illegal_o   <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid_o <= 1'b1;
      result_o    <= alu_result;
      illegal_o   <= alu_illegal;
    end else if (mul_done) begin
      out_valid_o <= 1'b1;
      result_o    <= mul_product;
      illegal_o   <= 1'b0;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_eu_pipe.sv
// Directed self-checking bench for eu_pipe; follows EU_MUL_EN for MUL expectations.
module tb_eu_pipe;
  import simple_processor_pkg::*;

  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          arst_ni;
  logic          in_valid_i;
  logic          in_ready_o;
  func_t         func_i;
  logic [DW-1:0] rs1_data_i;
  logic [DW-1:0] rs2_data_i;
  logic [5:0]    imm_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] result_o;
  logic          illegal_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  eu_pipe #(.DATA_WIDTH(DW), .IMM_WIDTH(6)) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .func_i      (func_i),
    .rs1_data_i  (rs1_data_i),
    .rs2_data_i  (rs2_data_i),
    .imm_i       (imm_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .illegal_o   (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input func_t f, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [5:0] imm);
    in_valid_i = 1'b1;
    func_i     = f;
    rs1_data_i = a;
    rs2_data_i = b;
    imm_i      = imm;
  endtask

  task automatic test_reset();
    arst_ni     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    func_i      = FUNC_AND;
    rs1_data_i  = '0;
    rs2_data_i  = '0;
    imm_i       = '0;
    #12;
    total_cnt++;
    if ({out_valid_o, illegal_o, in_ready_o} !== 3'b001 || result_o !== 32'h0)
      $display("FAIL reset: valid=%b illegal=%b ready=%b result=%h, want 0 0 1 0",
               out_valid_o, illegal_o, in_ready_o, result_o);
    else pass_cnt++;
    arst_ni = 1'b1;
    tick();
  endtask

  // Back-to-back single-cycle ops with in_valid held high.
  task automatic test_single_ops();
    func_t         f   [12] = '{FUNC_ADD, FUNC_ADDI, FUNC_SUB, FUNC_SLRI, FUNC_SLL, FUNC_AND,
                                FUNC_OR, FUNC_XOR, FUNC_NOT, FUNC_SLR, FUNC_SLLI, func_t'(4'hF)};
    logic [DW-1:0] a   [12] = '{32'd5, 32'd10, 32'd3, 32'h8000_0000, 32'd1, 32'h0000_F0F0,
                                32'h0000_F0F0, 32'h0000_F0F0, 32'h0, 32'h8000_0000, 32'd1, 32'h1234};
    logic [DW-1:0] b   [12] = '{32'd7, 32'd0, 32'd5, 32'd0, 32'd33, 32'h0000_FF00,
                                32'h0000_FF00, 32'h0000_FF00, 32'h0, 32'd31, 32'd0, 32'h5678};
    logic [5:0]    im  [12] = '{6'd0, 6'b111111, 6'd0, 6'd4, 6'd0, 6'd0,
                                6'd0, 6'd0, 6'd0, 6'd0, 6'b100001, 6'd0};
    logic [DW-1:0] exp [12] = '{32'd12, 32'd9, 32'hFFFF_FFFE, 32'h0800_0000, 32'h2, 32'h0000_F000,
                                32'h0000_FFF0, 32'h0000_0FF0, 32'hFFFF_FFFF, 32'h1, 32'h2, 32'h0};
    logic          ill [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    out_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(f[i], a[i], b[i], im[i]);
      tick();
      total_cnt++;
      if (out_valid_o !== 1'b1 || result_o !== exp[i] || illegal_o !== ill[i] || in_ready_o !== 1'b1)
        $display("FAIL op%0d func=%0d: valid=%b result=%h illegal=%b ready=%b, want 1 %h %b 1",
                 i, f[i], out_valid_o, result_o, illegal_o, in_ready_o, exp[i], ill[i]);
      else pass_cnt++;
    end
    in_valid_i = 1'b0;
    tick();
    total_cnt++;
    if (out_valid_o !== 1'b0)
      $display("FAIL drain_idle: valid=%b, want 0", out_valid_o);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    out_ready_i = 1'b0;
    drive(FUNC_XOR, 32'h0000_00A5, 32'h0000_000F, 6'd0);
    tick();
    drive(FUNC_ADD, 32'd1, 32'd2, 6'd0);
    for (int c = 0; c < 3; c++) begin
      total_cnt++;
      if (out_valid_o !== 1'b1 || result_o !== 32'h0000_00AA || in_ready_o !== 1'b0)
        $display("FAIL stall%0d: valid=%b result=%h ready=%b, want 1 000000aa 0",
                 c, out_valid_o, result_o, in_ready_o);
      else pass_cnt++;
      tick();
    end
    out_ready_i = 1'b1;
    #1;
    total_cnt++;
    if (in_ready_o !== 1'b1)
      $display("FAIL drain_ready: ready=%b, want 1", in_ready_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid_o !== 1'b1 || result_o !== 32'd3)
      $display("FAIL drain_and_load: valid=%b result=%h, want 1 00000003", out_valid_o, result_o);
    else pass_cnt++;
    in_valid_i = 1'b0;
    tick();
    total_cnt++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1)
      $display("FAIL post_drain: valid=%b ready=%b, want 0 1", out_valid_o, in_ready_o);
    else pass_cnt++;
  endtask

  task automatic test_mul();
    logic [DW-1:0] ma [2] = '{32'd3, 32'hFFFF_FFFF};
    logic [DW-1:0] mb [2] = '{32'd5, 32'd2};
    logic [DW-1:0] me [2] = '{32'd15, 32'hFFFF_FFFE};
    out_ready_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(FUNC_MUL, ma[k], mb[k], 6'd0);
      tick();
      in_valid_i = 1'b0;
`ifdef EU_MUL_EN
      begin
        int bad = 0;
        for (int c = 1; c < DW; c++) begin
          if (out_valid_o !== 1'b0 || in_ready_o !== 1'b0) bad++;
          tick();
        end
        total_cnt++;
        if (bad != 0)
          $display("FAIL mul%0d_busy: %0d cycles with valid or ready high, want 0", k, bad);
        else pass_cnt++;
      end
      total_cnt++;
      if (out_valid_o !== 1'b1 || result_o !== me[k] || illegal_o !== 1'b0)
        $display("FAIL mul%0d: valid=%b result=%h illegal=%b, want 1 %h 0",
                 k, out_valid_o, result_o, illegal_o, me[k]);
      else pass_cnt++;
`else
      total_cnt++;
      if (out_valid_o !== 1'b1 || result_o !== 32'h0 || illegal_o !== 1'b1 || in_ready_o !== 1'b1)
        $display("FAIL mul%0d_disabled: valid=%b result=%h illegal=%b ready=%b, want 1 0 1 1 (a*b=%h unused)",
                 k, out_valid_o, result_o, illegal_o, in_ready_o, me[k]);
      else pass_cnt++;
`endif
      tick();
    end
  endtask

  task automatic test_async_reset();
    out_ready_i = 1'b1;
`ifdef EU_MUL_EN
    drive(FUNC_MUL, 32'd7, 32'd9, 6'd0);
    tick();
    in_valid_i = 1'b0;
    for (int c = 0; c < 10; c++) tick();
`else
    out_ready_i = 1'b0;
    drive(FUNC_ADD, 32'd4, 32'd4, 6'd0);
    tick();
    in_valid_i = 1'b0;
    tick();
`endif
    #2;
    arst_ni = 1'b0;
    #1;
    total_cnt++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || result_o !== 32'h0)
      $display("FAIL async_reset: valid=%b ready=%b result=%h, want 0 1 0",
               out_valid_o, in_ready_o, result_o);
    else pass_cnt++;
    #1;
    arst_ni     = 1'b1;
    out_ready_i = 1'b1;
    tick();
    drive(FUNC_ADD, 32'd1, 32'd1, 6'd0);
    tick();
    in_valid_i = 1'b0;
    total_cnt++;
    if (out_valid_o !== 1'b1 || result_o !== 32'd2 || illegal_o !== 1'b0)
      $display("FAIL add_after_reset: valid=%b result=%h illegal=%b, want 1 00000002 0",
               out_valid_o, result_o, illegal_o);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_backpressure();
    test_mul();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
